// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
//   Builds a 3x3 pixel window from a raster-order stream for the Sobel
//   position calculator. Two line buffers (depth = one row) hold the two
//   previous rows; a 3x3 shift register holds the window itself.
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   pix_valid        pixel present this cycle (no backpressure)
//   pix_data         pixel value, raster order
//   pix_sof          start-of-frame marker, qualified by pix_valid
//   a11..a13         window row two rows back (a13 = newest column)
//   a21..a23         window row one row back
//   a31..a33         window current row (a33 = latest accepted pixel)
//   count_en         window updated this cycle (one pulse per pixel)
//   frame_done       pulse with count_en of the last pixel of a frame
//   sync_err         pulse with count_en of an out-of-place pix_sof
module sobel_window_3x3 #(
  parameter int RAW_FRAME_COLNUM = 1920,
  parameter int RAW_FRAME_ROWNUM = 1080,
  parameter int DATA_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] a12,
  output logic [DATA_W-1:0] a13,
  output logic [DATA_W-1:0] a21,
  output logic [DATA_W-1:0] a22,
  output logic [DATA_W-1:0] a23,
  output logic [DATA_W-1:0] a31,
  output logic [DATA_W-1:0] a32,
  output logic [DATA_W-1:0] a33,
  output logic              count_en,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int          ADDR_W   = $clog2(RAW_FRAME_COLNUM);
  localparam logic [11:0] COL_LAST = 12'(RAW_FRAME_COLNUM - 1);
  localparam logic [11:0] ROW_LAST = 12'(RAW_FRAME_ROWNUM - 1);

  logic [11:0]       col_cnt;
  logic [11:0]       row_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] lb1_old;
  logic [DATA_W-1:0] lb2_old;

  // lb1 holds the previous row, lb2 the row before that.
  logic [DATA_W-1:0] lb1 [RAW_FRAME_COLNUM];
  logic [DATA_W-1:0] lb2 [RAW_FRAME_COLNUM];

  // A pix_sof pixel is always placed at column 0, wherever the counters are.
  always_comb begin
    addr    = pix_sof ? '0 : ADDR_W'(col_cnt);
    lb1_old = lb1[addr];
    lb2_old = lb2[addr];
  end

  // Read-before-write: the row in lb1 cascades into lb2 as the new pixel lands.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[addr] <= pix_data;
      lb2[addr] <= lb1_old;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a11        <= '0;
      a12        <= '0;
      a13        <= '0;
      a21        <= '0;
      a22        <= '0;
      a23        <= '0;
      a31        <= '0;
      a32        <= '0;
      a33        <= '0;
      count_en   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else begin
      count_en   <= pix_valid;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (pix_valid) begin
        a11 <= a12;
        a12 <= a13;
        a13 <= lb2_old;
        a21 <= a22;
        a22 <= a23;
        a23 <= lb1_old;
        a31 <= a32;
        a32 <= a33;
        a33 <= pix_data;
        if (pix_sof) begin
          // Resynchronise: this pixel is (0,0), so the next one is (0,1).
          sync_err <= (row_cnt != '0) || (col_cnt != '0);
          row_cnt  <= '0;
          col_cnt  <= 12'd1;
        end else if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          if (row_cnt == ROW_LAST) begin
            row_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 12'd1;
          end
        end else begin
          col_cnt <= col_cnt + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb_sobel_window_3x3
//   Directed bench for sobel_window_3x3 with an 8x6 frame and
//   pixel value = row*16 + col. Expected windows are hand-computed.
module tb_sobel_window_3x3;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int NPIX = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_sof;
  logic [7:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
  logic       count_en, frame_done, sync_err;
  logic [71:0] win;

  int errors = 0;
  int checks = 0;
  int ce_cnt = 0;
  int fd_cnt = 0;

  typedef struct {
    int          r;
    int          c;
    logic [71:0] win;
  } vec_t;

  localparam int NV = 5;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  assign win = {a11, a12, a13, a21, a22, a23, a31, a32, a33};

  sobel_window_3x3 #(
    .RAW_FRAME_COLNUM(COLS),
    .RAW_FRAME_ROWNUM(ROWS),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_sof(pix_sof),
    .a11(a11), .a12(a12), .a13(a13),
    .a21(a21), .a22(a22), .a23(a23),
    .a31(a31), .a32(a32), .a33(a33),
    .count_en(count_en),
    .frame_done(frame_done),
    .sync_err(sync_err)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic sample();
    if (count_en) ce_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic push(input logic [7:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    @(posedge clk);
    #1;
    sample();
  endtask

  // Idle cycle; pix_sof is driven high to show it is ignored without pix_valid.
  task automatic idle();
    pix_valid = 1'b0;
    pix_data  = 8'hEE;
    pix_sof   = 1'b1;
    @(posedge clk);
    #1;
    sample();
  endtask

  // Sends linear pixel indices first..last of a frame; index 0 carries d00
  // and pix_sof. Optional idle cycle after every pixel.
  task automatic run_frame(input bit gapped, input logic [7:0] d00,
                           input int first, input int last);
    int          r;
    int          c;
    bit          hit;
    logic [71:0] exp;
    ce_cnt = 0;
    fd_cnt = 0;
    for (int i = first; i <= last; i++) begin
      r = i / COLS;
      c = i % COLS;
      push((i == 0) ? d00 : 8'(r * 16 + c), i == 0);
      check("count_en", 72'(count_en), 72'd1);
      check("sync_err", 72'(sync_err), 72'd0);
      check("frame_done", 72'(frame_done), 72'(i == NPIX - 1));
      hit = 1'b0;
      exp = '0;
      for (int k = 0; k < NV; k++) begin
        if (tbl[k].r == r && tbl[k].c == c) begin
          hit = 1'b1;
          exp = tbl[k].win;
        end
      end
      if (r == 2 && c == 2) exp[71:64] = d00;
      if (hit) check("window", win, exp);
      if (gapped) begin
        idle();
        check("gap_count_en", 72'(count_en), 72'd0);
        check("gap_sync_err", 72'(sync_err), 72'd0);
        check("gap_frame_done", 72'(frame_done), 72'd0);
        if (hit) check("gap_window_hold", win, exp);
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    if (first == 0 && last == NPIX - 1) begin
      check("frame_count_en_pulses", 72'(ce_cnt), 72'(NPIX));
      check("frame_done_pulses", 72'(fd_cnt), 72'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2, 2, 72'h00_01_02_10_11_12_20_21_22};
    tbl[1] = '{2, 7, 72'h05_06_07_15_16_17_25_26_27};
    tbl[2] = '{3, 5, 72'h13_14_15_23_24_25_33_34_35};
    tbl[3] = '{4, 3, 72'h21_22_23_31_32_33_41_42_43};
    tbl[4] = '{5, 7, 72'h35_36_37_45_46_47_55_56_57};

    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_window", win, '0);
    check("reset_count_en", 72'(count_en), 72'd0);
    check("reset_frame_done", 72'(frame_done), 72'd0);
    check("reset_sync_err", 72'(sync_err), 72'd0);
    rst = 1'b0;

    // Two back-to-back continuous frames, then a gapped one.
    run_frame(1'b0, 8'h00, 0, NPIX - 1);
    run_frame(1'b0, 8'h00, 0, NPIX - 1);
    run_frame(1'b1, 8'h00, 0, NPIX - 1);

    // Out-of-place pix_sof at (3,4) carrying 0xAA restarts the frame.
    run_frame(1'b0, 8'h00, 0, 3 * COLS + 3);
    push(8'hAA, 1'b1);
    check("sof_sync_err", 72'(sync_err), 72'd1);
    check("sof_count_en", 72'(count_en), 72'd1);
    check("sof_frame_done", 72'(frame_done), 72'd0);
    check("sof_a33", 72'(a33), 72'hAA);
    // Remainder of that frame runs from (0,1); its (2,2) window sees 0xAA at a11.
    run_frame(1'b0, 8'hAA, 1, NPIX - 1);
    // Counters realigned: a normal frame with pix_sof first raises no sync_err.
    run_frame(1'b0, 8'h00, 0, NPIX - 1);

    // Reset mid-frame while a pixel for (4,5) is offered.
    run_frame(1'b0, 8'h00, 0, 4 * COLS + 4);
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'h45;
    pix_sof   = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_window", win, '0);
    check("midrst_count_en", 72'(count_en), 72'd0);
    check("midrst_frame_done", 72'(frame_done), 72'd0);
    check("midrst_sync_err", 72'(sync_err), 72'd0);
    rst       = 1'b0;
    pix_valid = 1'b0;
    run_frame(1'b0, 8'h00, 0, NPIX - 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
